// File: rtl/data_memory_responder.sv
// Data-memory responder for the core's MA-stage port: stalls the core for a
// programmable latency, then performs a byte/half/word access on a word array.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ADDR,
  input  logic [31:0] WRITEDATA,
  input  logic [3:0]  READ,
  input  logic [2:0]  WRITE,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT,
  output logic        MISALIGN,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Handshake: the core holds its request (req) stable while BUSYWAIT is high;
  // the request is taken on the IDLE edge and the result is valid in DONE,
  // the one cycle BUSYWAIT is low, on whose closing edge the core advances.
  logic req;
  assign req = READ[3] | WRITE[2];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          store_q, store_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    wsize_q, wsize_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          misalign_q, misalign_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          unused_addr;
  assign unused_addr = ^ADDR[31:AW+2];

  logic          access_fire;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   mem_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_result;
  logic [3:0]    be;
  logic [31:0]   wbytes;
  logic          mem_we;
  logic          mis_calc;

  assign access_fire = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign widx        = addr_q[AW+1:2];
  assign lane        = addr_q[1:0];
  assign mem_word    = mem[widx];
  assign byte_sel    = mem_word[{lane, 3'b000} +: 8];
  assign half_sel    = addr_q[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_result = '0;
    case (funct3_q)
      3'b000:  load_result = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_result = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_result = mem_word;
      3'b100:  load_result = {24'd0, byte_sel};
      3'b101:  load_result = {16'd0, half_sel};
      default: load_result = '0;
    endcase
  end

  // Half stores use lanes {addr[1],0}/{addr[1],1}; word stores ignore addr[1:0].
  always_comb begin
    be     = 4'b0000;
    wbytes = wdata_q;
    case (wsize_q)
      2'b00: begin
        be     = 4'b0001 << lane;
        wbytes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wbytes = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be     = 4'b1111;
        wbytes = wdata_q;
      end
      default: begin
        be     = 4'b0000;
        wbytes = wdata_q;
      end
    endcase
  end

  assign mem_we = access_fire && store_q;

  always_comb begin
    mis_calc = 1'b0;
    if (store_q) begin
      mis_calc = ((wsize_q == 2'b01) && addr_q[0]) ||
                 ((wsize_q == 2'b10) && (addr_q[1:0] != 2'b00));
    end else begin
      mis_calc = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((funct3_q == 3'b010) && (addr_q[1:0] != 2'b00));
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    store_d    = store_q;
    funct3_d   = funct3_q;
    wsize_d    = wsize_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d   = ADDR[AW+1:0];
          wdata_d  = WRITEDATA;
          store_d  = WRITE[2];
          funct3_d = READ[2:0];
          wsize_d  = WRITE[1:0];
          cnt_d    = CW'(LATENCY - 1);
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (!store_q) rdata_d = load_result;
          misalign_d = mis_calc;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      funct3_q   <= 3'b000;
      wsize_q    <= 2'b00;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      store_q    <= store_d;
      funct3_q   <= funct3_d;
      wsize_q    <= wsize_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Array is never reset; a reset during ACCESS returns to IDLE before the write edge.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wbytes[8*i +: 8];
      end
    end
  end

  assign BUSYWAIT  = RST && (((state_q == ST_IDLE) && req) || (state_q == ST_ACCESS));
  assign READDATA  = rdata_q;
  assign MISALIGN  = misalign_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (LATENCY=2, DEPTH_WORDS=256).
module tb_data_memory_responder;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ADDR;
  logic [31:0] WRITEDATA;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] READDATA;
  logic        BUSYWAIT;
  logic        MISALIGN;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .WRITEDATA(WRITEDATA),
    .READ(READ), .WRITE(WRITE), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MISALIGN(MISALIGN), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Starts one posedge+1 into IDLE, ends one posedge+1 into the following IDLE.
  task automatic txn(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic [31:0] mask,
                     input logic exp_mis);
    int          busy;
    logic [31:0] rdata;
    logic        mis;
    logic [1:0]  st;
    READ = rd; WRITE = wr; ADDR = a; WRITEDATA = wd;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      busy++;
      if (busy >= 2) begin
        ADDR = ~a;
        WRITEDATA = ~wd;
      end
    end
    rdata = READDATA;
    mis   = MISALIGN;
    st    = dbg_state;
    READ = 4'b0000; WRITE = 3'b000;
    check({tag, "_busy"}, 32'(busy), 32'(LAT + 1));
    check({tag, "_state"}, 32'(st), 32'd2);
    check({tag, "_rdata"}, rdata & mask, exp_rd & mask);
    check({tag, "_mis"}, 32'(mis), 32'(exp_mis));
    @(posedge CLK); #1;
    check({tag, "_mis_after"}, 32'(MISALIGN), 32'd0);
  endtask

  initial begin
    RST = 1'b0; ADDR = '0; WRITEDATA = '0; READ = 4'b0000; WRITE = 3'b000;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", 32'(BUSYWAIT), 32'd0);
    check("rst_rdata", READDATA, 32'd0);
    check("rst_mis", 32'(MISALIGN), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // word store/load
    txn("sw_10",   4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, 32'h0,        32'hFFFFFFFF, 1'b0);
    txn("lw_10",   4'b1010, 3'b000, 32'h10, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b0);
    // byte lanes
    txn("sb_13",   4'b0000, 3'b100, 32'h13, 32'h00000080, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0);
    txn("lb_13",   4'b1000, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 32'hFFFFFFFF, 1'b0);
    txn("lbu_13",  4'b1100, 3'b000, 32'h13, 32'h0,        32'h00000080, 32'hFFFFFFFF, 1'b0);
    txn("lw_10b",  4'b1010, 3'b000, 32'h10, 32'h0,        32'h80ADBEEF, 32'hFFFFFFFF, 1'b0);
    // halfwords
    txn("sh_22",   4'b0000, 3'b101, 32'h22, 32'h00008001, 32'h80ADBEEF, 32'hFFFFFFFF, 1'b0);
    txn("lh_22",   4'b1001, 3'b000, 32'h22, 32'h0,        32'hFFFF8001, 32'hFFFFFFFF, 1'b0);
    txn("lhu_22",  4'b1101, 3'b000, 32'h22, 32'h0,        32'h00008001, 32'hFFFFFFFF, 1'b0);
    txn("lw_20",   4'b1010, 3'b000, 32'h20, 32'h0,        32'h80010000, 32'hFFFF0000, 1'b0);
    txn("sh_20",   4'b0000, 3'b101, 32'h20, 32'h00001234, 32'h80010000, 32'hFFFF0000, 1'b0);
    // misaligned accesses complete at the aligned-down address
    txn("lh_21",   4'b1001, 3'b000, 32'h21, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1);
    txn("lw_12",   4'b1010, 3'b000, 32'h12, 32'h0,        32'h80ADBEEF, 32'hFFFFFFFF, 1'b1);
    txn("sh_23",   4'b0000, 3'b101, 32'h23, 32'h00007777, 32'h80ADBEEF, 32'hFFFFFFFF, 1'b1);
    txn("lw_20b",  4'b1010, 3'b000, 32'h20, 32'h0,        32'h77771234, 32'hFFFFFFFF, 1'b0);
    txn("lb_11",   4'b1000, 3'b000, 32'h11, 32'h0,        32'hFFFFFFBE, 32'hFFFFFFFF, 1'b0);
    txn("undef_f3",4'b1011, 3'b000, 32'h10, 32'h0,        32'h00000000, 32'hFFFFFFFF, 1'b0);
    txn("sw_40",   4'b0000, 3'b110, 32'h40, 32'h0BADF00D, 32'h00000000, 32'hFFFFFFFF, 1'b0);
    txn("lw_40",   4'b1010, 3'b000, 32'h40, 32'h0,        32'h0BADF00D, 32'hFFFFFFFF, 1'b0);

    // reset in the second ACCESS cycle of a store
    READ = 4'b0000; WRITE = 3'b110; ADDR = 32'h40; WRITEDATA = 32'h12345678;
    @(posedge CLK);
    @(posedge CLK); #1;
    check("abort_pre_state", 32'(dbg_state), 32'd1);
    check("abort_pre_busy", 32'(BUSYWAIT), 32'd1);
    #1 RST = 1'b0;
    #1;
    check("abort_busy", 32'(BUSYWAIT), 32'd0);
    check("abort_rdata", READDATA, 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    READ = 4'b0000; WRITE = 3'b000;
    @(posedge CLK); #1;
    check("abort_hold_state", 32'(dbg_state), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("abort_idle_busy", 32'(BUSYWAIT), 32'd0);
    txn("lw_40_post", 4'b1010, 3'b000, 32'h40, 32'h0, 32'h0BADF00D, 32'hFFFFFFFF, 1'b0);

    // load and store both requested -> store wins, READDATA untouched
    txn("both_50", 4'b1010, 3'b110, 32'h50,  32'hA5A5A5A5, 32'h0BADF00D, 32'hFFFFFFFF, 1'b0);
    txn("lw_450",  4'b1010, 3'b000, 32'h450, 32'h0,        32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
